// File: rtl/msh_pkg.sv
// Shared mesh types for the read-request ingress path.
// Request bundle layout and credit controller states.
package msh_pkg;

    localparam int MSH_RD_ADDR_W = 20;
    localparam int MSH_RD_ID_W   = 8;
    localparam int MSH_PORT_W    = 2;

    typedef struct packed {
        logic [MSH_RD_ADDR_W-1:0] addr;
        logic [MSH_RD_ID_W-1:0]   id;
        logic [MSH_PORT_W-1:0]    port;
    } msh_rd_req_t;

    typedef enum logic {
        INQ_INIT,
        INQ_RUN
    } msh_inq_crd_st_e;

endpackage

// File: rtl/msh_inq_crd_ctl.sv
// Credit return controller for the read-request ingress queue.
// Grants DEPTH credits after reset, then returns one per dequeue.
module msh_inq_crd_ctl
    import msh_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic mclk,
    input  logic mrst_n,
    input  logic deq,
    output logic crd
);

    localparam logic [CNT_W-1:0] LAST_INIT = CNT_W'(DEPTH - 1);

    msh_inq_crd_st_e  state_q;
    logic [CNT_W-1:0] init_q;
    logic [CNT_W-1:0] pend_q;
    logic             crd_q;

    // Init grant first; dequeues owed meanwhile drain once RUN begins.
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            state_q <= INQ_INIT;
            init_q  <= '0;
            pend_q  <= '0;
            crd_q   <= 1'b0;
        end else begin
            case (state_q)
                INQ_INIT: begin
                    crd_q  <= 1'b1;
                    init_q <= init_q + 1'b1;
                    pend_q <= pend_q + CNT_W'(deq);
                    if (init_q == LAST_INIT) begin
                        state_q <= INQ_RUN;
                    end
                end
                INQ_RUN: begin
                    if (pend_q != '0) begin
                        crd_q  <= 1'b1;
                        pend_q <= pend_q - 1'b1 + CNT_W'(deq);
                    end else begin
                        crd_q  <= 1'b0;
                        pend_q <= pend_q + CNT_W'(deq);
                    end
                end
                default: begin
                    state_q <= INQ_INIT;
                    crd_q   <= 1'b0;
                end
            endcase
        end
    end

    assign crd = crd_q;

endmodule

// File: rtl/msh_rd_req_inq.sv
// Credit-controlled ingress FIFO for mesh read requests.
// Feeds msh_rd_req over valid/ready and flags writes into a full queue.
module msh_rd_req_inq
    import msh_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = MSH_RD_ADDR_W,
    parameter int ID_W   = MSH_RD_ID_W,
    parameter int PORT_W = MSH_PORT_W
) (
    input  logic                       mclk,
    input  logic                       mrst_n,
    input  logic                       i_rd_req_vld,
    input  logic [ADDR_W-1:0]          i_rd_req_addr,
    input  logic [ID_W-1:0]            i_rd_req_id,
    input  logic [PORT_W-1:0]          i_rd_req_port,
    output logic                       o_rd_req_crd,
    output logic                       o_rd_req_vld,
    input  logic                       i_rd_req_rdy,
    output logic [ADDR_W-1:0]          o_rd_req_addr,
    output logic [ID_W-1:0]            o_rd_req_id,
    output logic [PORT_W-1:0]          o_rd_req_port,
    output logic [$clog2(DEPTH+1)-1:0] o_inq_cnt,
    output logic                       o_ovfl_err,
    input  logic                       i_err_clr
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    msh_rd_req_t      mem_q [DEPTH];
    msh_rd_req_t      wr_ent;
    msh_rd_req_t      head;
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    logic full;
    logic vld;
    logic deq;
    logic enq_ok;
    logic ovfl;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full   = (cnt_q == FULL_CNT);
    assign vld    = (cnt_q != '0);
    assign deq    = vld & i_rd_req_rdy;
    assign enq_ok = i_rd_req_vld & (~full | deq);
    assign ovfl   = i_rd_req_vld & full & ~deq;

    assign wr_ent = '{addr: i_rd_req_addr, id: i_rd_req_id, port: i_rd_req_port};

    // Payload storage; validity is tracked by cnt_q so no reset needed.
    always_ff @(posedge mclk) begin
        if (enq_ok) begin
            mem_q[wptr_q] <= wr_ent;
        end
    end

    // Pointers and occupancy; full/empty come from the count.
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (enq_ok) begin
                wptr_q <= ptr_inc(wptr_q);
            end
            if (deq) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            case ({enq_ok, deq})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Sticky overflow flag; a new overflow beats a same-cycle clear.
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            err_q <= 1'b0;
        end else if (ovfl) begin
            err_q <= 1'b1;
        end else if (i_err_clr) begin
            err_q <= 1'b0;
        end
    end

    msh_inq_crd_ctl #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_crd_ctl (
        .mclk   (mclk),
        .mrst_n (mrst_n),
        .deq    (deq),
        .crd    (o_rd_req_crd)
    );

    assign head          = mem_q[rptr_q];
    assign o_rd_req_vld  = vld;
    assign o_rd_req_addr = vld ? head.addr : '0;
    assign o_rd_req_id   = vld ? head.id : '0;
    assign o_rd_req_port = vld ? head.port : '0;
    assign o_inq_cnt     = cnt_q;
    assign o_ovfl_err    = err_q;

endmodule

// File: tb/tb_msh_rd_req_inq.sv
// Self-checking bench for msh_rd_req_inq.
// Queue-level reference model plus directed literal checks.
module tb_msh_rd_req_inq;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic [19:0] a;
        logic [7:0]  id;
        logic [1:0]  p;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        vld;
    logic [19:0] addr;
    logic [7:0]  id;
    logic [1:0]  port;
    logic        rdy;
    logic        clr;
    logic        crd;
    logic        o_vld;
    logic [19:0] o_addr;
    logic [7:0]  o_id;
    logic [1:0]  o_port;
    logic [3:0]  cnt;
    logic        err;

    int ntests = 0;
    int nfail  = 0;

    // reference model state
    ent_t mq[$];
    bit   m_err;
    bit   m_crd;
    int   m_edges;
    int   m_sent;
    int   m_deqs;
    bit   m_d;
    bit   m_ov;

    msh_rd_req_inq dut (
        .mclk          (clk),
        .mrst_n        (rst_n),
        .i_rd_req_vld  (vld),
        .i_rd_req_addr (addr),
        .i_rd_req_id   (id),
        .i_rd_req_port (port),
        .o_rd_req_crd  (crd),
        .o_rd_req_vld  (o_vld),
        .i_rd_req_rdy  (rdy),
        .o_rd_req_addr (o_addr),
        .o_rd_req_id   (o_id),
        .o_rd_req_port (o_port),
        .o_inq_cnt     (cnt),
        .o_ovfl_err    (err),
        .i_err_clr     (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: FIFO of entries; credits owed = DEPTH init + one per earlier dequeue.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_err   = 1'b0;
            m_crd   = 1'b0;
            m_edges = 0;
            m_sent  = 0;
            m_deqs  = 0;
        end else begin
            m_d  = (mq.size() != 0) && rdy;
            m_ov = vld && (mq.size() == DEPTH) && !m_d;
            if (m_d) void'(mq.pop_front());
            if (vld && !m_ov) mq.push_back('{a: addr, id: id, p: port});
            if (m_ov) m_err = 1'b1;
            else if (clr) m_err = 1'b0;
            m_edges++;
            if (m_edges <= DEPTH) m_crd = 1'b1;
            else m_crd = (m_sent < DEPTH + m_deqs);
            if (m_crd) m_sent++;
            if (m_d) m_deqs++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("vld", o_vld, mq.size() != 0);
        chk("cnt", cnt, mq.size());
        chk("err", err, m_err);
        chk("crd", crd, m_crd);
        if (mq.size() != 0) begin
            chk("head_addr", o_addr, mq[0].a);
            chk("head_id", o_id, mq[0].id);
            chk("head_port", o_port, mq[0].p);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_in();
        vld  = 1'b0;
        addr = '0;
        id   = '0;
        port = '0;
        clr  = 1'b0;
    endtask

    task automatic init_check(input string nm);
        int  n;
        bit  consec;
        n = 0;
        consec = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (crd) n++;
            if (i <= DEPTH && !crd) consec = 1'b0;
        end
        chk({nm, "_ncrd"}, n, DEPTH);
        chk({nm, "_consec"}, 32'(consec), 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_vld", o_vld, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_err", err, 0);
        chk("rst_crd", crd, 0);
        chk("rst_id", o_id, 0);
        cyc();
        idle_in();
        rdy = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        int   ids[$];
        int   cred;
        int   nreq;
        int   tot;
        rst_n = 1'b0;
        idle_in();
        rdy = 1'b0;
        repeat (3) cyc();
        chk("por_cnt", cnt, 0);
        chk("por_crd", crd, 0);
        rst_n = 1'b1;

        // init credit grant with no traffic
        init_check("init");
        chk("init_cnt", cnt, 0);

        // single request, sink ready
        rdy  = 1'b1;
        vld  = 1'b1;
        addr = 20'h12345;
        id   = 8'h5A;
        port = 2'd2;
        cyc();
        idle_in();
        chk("one_vld", o_vld, 1);
        chk("one_addr", o_addr, 32'h12345);
        chk("one_id", o_id, 32'h5A);
        chk("one_port", o_port, 2);
        chk("one_crd0", crd, 0);
        cyc();
        chk("one_vld_off", o_vld, 0);
        chk("one_crd1", crd, 0);
        cyc();
        chk("one_crd2", crd, 1);
        cyc();
        chk("one_crd3", crd, 0);

        // fill, overflow, clear
        rdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            vld  = 1'b1;
            id   = 8'(i);
            addr = 20'($urandom);
            port = 2'(i);
            cyc();
        end
        chk("full_cnt", cnt, 8);
        chk("full_err", err, 0);
        id = 8'hFF;
        cyc();
        vld = 1'b0;
        chk("ovfl_err", err, 1);
        chk("ovfl_cnt", cnt, 8);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("clr_err", err, 0);

        // full with simultaneous dequeue and write, then drain
        for (int i = 8; i < 16; i++) begin
            vld  = 1'b1;
            id   = 8'(i);
            addr = 20'($urandom);
            rdy  = 1'b1;
            if (o_vld) ids.push_back(int'(o_id));
            cyc();
        end
        vld = 1'b0;
        chk("wrap_cnt", cnt, 8);
        chk("wrap_err", err, 0);
        for (int i = 0; i < DEPTH; i++) begin
            if (o_vld) ids.push_back(int'(o_id));
            cyc();
        end
        chk("wrap_n", ids.size(), 16);
        for (int i = 0; i < ids.size(); i++) chk("wrap_order", ids[i], i);

        // reset mid-operation with occupancy and an error pending
        repeat (12) cyc();
        rdy = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            vld = 1'b1;
            id  = 8'(i + 32);
            cyc();
        end
        vld = 1'b0;
        rdy = 1'b1;
        repeat (3) cyc();
        rdy = 1'b0;
        chk("pre_rst_cnt", cnt, 5);
        chk("pre_rst_err", err, 1);
        do_reset();
        init_check("reinit");

        // random traffic with a credit-obeying sender
        do_reset();
        cred = 0;
        nreq = 0;
        tot  = 0;
        for (int k = 0; k < 20000 && nreq < 1000; k++) begin
            if (crd) begin
                cred++;
                tot++;
            end
            rdy = ($urandom_range(0, 3) != 0);
            if (cred > 0 && $urandom_range(0, 9) < 7) begin
                vld  = 1'b1;
                addr = 20'($urandom);
                id   = 8'(nreq);
                port = 2'($urandom);
                cred--;
                nreq++;
            end else begin
                vld = 1'b0;
            end
            cyc();
        end
        vld = 1'b0;
        rdy = 1'b1;
        chk("rnd_sent", nreq, 1000);
        for (int k = 0; k < 200 && mq.size() != 0; k++) begin
            if (crd) begin
                cred++;
                tot++;
            end
            cyc();
        end
        chk("rnd_drain", mq.size(), 0);
        for (int k = 0; k < 20; k++) begin
            if (crd) begin
                cred++;
                tot++;
            end
            cyc();
        end
        chk("rnd_tot_crd", tot, DEPTH + 1000);
        chk("rnd_held_crd", cred, DEPTH);
        chk("rnd_err", err, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
